// File: rtl/tl_ul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_ul_pkg
//  Description : TileLink-UL opcode encodings and the D-channel response
//                entry carried by the responder's response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package tl_ul_pkg;

  // A-channel opcodes
  localparam logic [2:0] c_a_put_full    = 3'd0;
  localparam logic [2:0] c_a_put_partial = 3'd1;
  localparam logic [2:0] c_a_arith       = 3'd2;
  localparam logic [2:0] c_a_logical     = 3'd3;
  localparam logic [2:0] c_a_get         = 3'd4;
  localparam logic [2:0] c_a_intent      = 3'd5;

  // D-channel opcodes
  localparam logic [2:0] c_d_access_ack      = 3'd0;
  localparam logic [2:0] c_d_access_ack_data = 3'd1;
  localparam logic [2:0] c_d_hint_ack        = 3'd2;

  // Widest source id a queue entry can carry; SOURCE_W must not exceed this.
  localparam int c_source_w_max = 8;

  typedef struct packed {
    logic [2:0]                opcode;
    logic [1:0]                size;
    logic [c_source_w_max-1:0] source;
    logic                      denied;
    logic                      corrupt;
    logic [31:0]               data;
  } d_entry_t;

  // Byte lanes touched by a naturally aligned access of 2^size bytes.
  function automatic logic [3:0] size_lanes(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (size)
      2'd0:    lanes = 4'b0001 << addr_lo;
      2'd1:    lanes = 4'b0011 << {addr_lo[1], 1'b0};
      2'd2:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage : tl_ul_pkg
`default_nettype wire

// File: rtl/tl_ul_resp_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tl_ul_resp_queue
//  Description : Two-entry synchronous FIFO of D-channel response entries.
//                Head entry is always visible; enqueue and dequeue may occur
//                in the same cycle. Requests that would overflow/underflow
//                are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_resp_queue
  import tl_ul_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     enq,
  input  d_entry_t enq_entry,
  input  logic     deq,
  output d_entry_t head,
  output logic [1:0] count
);

  d_entry_t   r_slot [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;
  logic       w_enq_ok;
  logic       w_deq_ok;

  assign w_enq_ok = enq & (r_count != 2'd2);
  assign w_deq_ok = deq & (r_count != 2'd0);
  assign head     = r_slot[r_rd_ptr];
  assign count    = r_count;

  // Pointer and occupancy tracking; reset empties the queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq_ok) r_wr_ptr <= ~r_wr_ptr;
      if (w_deq_ok) r_rd_ptr <= ~r_rd_ptr;
      case ({w_enq_ok, w_deq_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clock) begin
    if (w_enq_ok && !reset) begin
      r_slot[r_wr_ptr] <= enq_entry;
    end
  end

endmodule : tl_ul_resp_queue
`default_nettype wire

// File: rtl/tl_ul_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tl_ul_ram_responder
//  Description : TileLink-UL responder serving Get / PutFull / PutPartial on
//                a local word-organised RAM. Unsupported or out-of-range
//                requests are denied. Responses pass through a 2-entry queue
//                so D-channel backpressure does not stall A acceptance until
//                the queue fills.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_ram_responder
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          SOURCE_W    = 3
) (
  input  logic                clock,
  input  logic                reset,
  // A channel
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  input  logic                a_corrupt,
  // D channel
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt
);

  localparam int          c_idx_w = $clog2(DEPTH_WORDS);
  localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);

  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_a_fire;
  logic               w_d_fire;
  logic [31:0]        w_offset;
  logic [29:0]        w_word;
  logic [c_idx_w-1:0] w_ram_idx;
  logic               w_in_range;
  logic               w_misaligned;
  logic               w_access_bad;
  logic [3:0]         w_full_lanes;
  logic               w_mem_we;
  d_entry_t           w_entry;
  d_entry_t           w_head;
  logic [1:0]         w_count;

  // Full queue blocks A even if D drains this cycle (no bypass path).
  assign a_ready  = ~reset & (w_count != 2'd2);
  assign w_a_fire = a_valid & a_ready;
  assign d_valid  = (w_count != 2'd0);
  assign w_d_fire = d_valid & d_ready;

  // Address decode: word index, range and natural-alignment checks.
  always_comb begin
    w_offset     = a_address - BASE_ADDR;
    w_word       = w_offset[31:2];
    w_ram_idx    = w_word[c_idx_w-1:0];
    w_in_range   = (a_address >= BASE_ADDR) && ({2'b00, w_word} < c_depth);
    w_full_lanes = size_lanes(a_size, a_address[1:0]);
    w_misaligned = 1'b0;
    case (a_size)
      2'd1:    w_misaligned = a_address[0];
      2'd2:    w_misaligned = |a_address[1:0];
      default: w_misaligned = 1'b0;
    endcase
    w_access_bad = ~w_in_range | (a_size == 2'd3) | w_misaligned;
  end

  // Opcode handling: build the response entry and decide on a RAM write.
  always_comb begin
    w_entry         = '0;
    w_entry.opcode  = c_d_access_ack;
    w_entry.size    = a_size;
    w_entry.source  = c_source_w_max'(a_source);
    w_mem_we        = 1'b0;
    case (a_opcode)
      c_a_get: begin
        w_entry.opcode = c_d_access_ack_data;
        if (w_access_bad) begin
          w_entry.denied  = 1'b1;
          w_entry.corrupt = 1'b1;
        end else begin
          w_entry.data = r_mem[w_ram_idx];
        end
      end
      c_a_put_full: begin
        // PutFull must carry exactly the lanes of its aligned size.
        if (w_access_bad || (a_mask != w_full_lanes)) begin
          w_entry.denied = 1'b1;
        end else begin
          w_mem_we = ~a_corrupt;
        end
      end
      c_a_put_partial: begin
        if (w_access_bad) begin
          w_entry.denied = 1'b1;
        end else begin
          w_mem_we = ~a_corrupt;
        end
      end
      c_a_arith, c_a_logical: begin
        w_entry.opcode  = c_d_access_ack_data;
        w_entry.denied  = 1'b1;
        w_entry.corrupt = 1'b1;
      end
      c_a_intent: begin
        w_entry.opcode = c_d_hint_ack;
      end
      default: begin
        w_entry.denied = 1'b1;
      end
    endcase
  end

  // RAM write: byte lanes committed only on the A-fire edge.
  always_ff @(posedge clock) begin
    if (w_a_fire && w_mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (a_mask[l]) begin
          r_mem[w_ram_idx][8*l +: 8] <= a_data[8*l +: 8];
        end
      end
    end
  end

  tl_ul_resp_queue u_resp_queue (
    .clock     (clock),
    .reset     (reset),
    .enq       (w_a_fire),
    .enq_entry (w_entry),
    .deq       (w_d_fire),
    .head      (w_head),
    .count     (w_count)
  );

  assign d_opcode  = w_head.opcode;
  assign d_param   = 2'b00;
  assign d_size    = w_head.size;
  assign d_source  = w_head.source[SOURCE_W-1:0];
  assign d_sink    = 1'b0;
  assign d_denied  = w_head.denied;
  assign d_data    = w_head.data;
  assign d_corrupt = w_head.corrupt;

  // a_param carries no meaning for this responder; the other bits are
  // consumed only partially by the decode.
  logic w_unused;
  assign w_unused = ^{a_param, w_offset[1:0], w_head.source};

endmodule : tl_ul_ram_responder
`default_nettype wire

// File: tb/tb_tl_ul_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tl_ul_ram_responder
//  Description : Self-checking bench for tl_ul_ram_responder. Table of
//                request/response vectors plus hand-written backpressure and
//                reset sequences; expected D beats queued at A fire and
//                compared when the DUT hands over the D beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_ul_ram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          SW   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [2:0]    a_opcode = '0;
  logic [2:0]    a_param = '0;
  logic [1:0]    a_size = '0;
  logic [SW-1:0] a_source = '0;
  logic [31:0]   a_address = '0;
  logic [3:0]    a_mask = '0;
  logic [31:0]   a_data = '0;
  logic          a_corrupt = 1'b0;
  logic          d_valid;
  logic          d_ready = 1'b1;
  logic [2:0]    d_opcode;
  logic [1:0]    d_param;
  logic [1:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_sink;
  logic          d_denied;
  logic [31:0]   d_data;
  logic          d_corrupt;

  tl_ul_ram_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (1024),
    .SOURCE_W    (SW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_corrupt (a_corrupt),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_sink    (d_sink),
    .d_denied  (d_denied),
    .d_data    (d_data),
    .d_corrupt (d_corrupt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    size;
    logic [SW-1:0] source;
    logic          den;
    logic          cor;
    logic [31:0]   data;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [31:0] e_data;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic [2:0] op, logic [1:0] size, logic [31:0] off,
                              logic [3:0] mask, logic [31:0] data, logic corrupt,
                              logic [2:0] e_op, logic e_den, logic e_cor,
                              logic [31:0] e_data);
    vec_t v;
    v.op = op; v.size = size; v.addr = BASE + off; v.mask = mask; v.data = data;
    v.corrupt = corrupt; v.e_op = e_op; v.e_den = e_den; v.e_cor = e_cor;
    v.e_data = e_data;
    return v;
  endfunction

  function automatic exp_t mk_exp(logic [2:0] op, logic [1:0] size, logic [SW-1:0] src,
                                  logic den, logic cor, logic [31:0] data);
    exp_t e;
    e.op = op; e.size = size; e.source = src; e.den = den; e.cor = cor; e.data = data;
    return e;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0b, expected %0b", name, got, want);
    end
  endtask

  // Drive one A beat and wait for it to be accepted; expected D beat is
  // queued at the moment of acceptance.
  task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [SW-1:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      input logic corrupt, input exp_t e, output int waited);
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = corrupt;
    waited = 0;
    forever begin
      @(negedge clock);
      if (a_ready) break;
      waited++;
      if (waited > 50) break;
    end
    if (waited > 50) begin
      n_vec++; n_miss++;
      $display("FAIL a_accept_timeout: a_ready stuck low, expected acceptance within 50 cycles");
    end else begin
      exp_q.push_back(e);
      @(posedge clock);
    end
    #1;
    a_valid = 1'b0;
  endtask

  // D-channel monitor: scoreboard compare on fire, stability check on stall.
  logic        stalled = 1'b0;
  logic [45:0] snap;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled && d_valid) begin
        n_vec++;
        if ({d_opcode, d_size, d_source, d_denied, d_corrupt, d_data} !== snap[42:0]) begin
          n_miss++;
          $display("FAIL d_stable: got %h, held value %h", {d_opcode, d_size, d_source,
                   d_denied, d_corrupt, d_data}, snap[42:0]);
        end
      end
      if (d_valid && d_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL d_unexpected: got op=%0d src=%0d data=%h, expected no response",
                   d_opcode, d_source, d_data);
        end else begin
          e = exp_q.pop_front();
          if (d_opcode !== e.op || d_size !== e.size || d_source !== e.source ||
              d_denied !== e.den || d_corrupt !== e.cor || d_data !== e.data ||
              d_param !== 2'b00 || d_sink !== 1'b0) begin
            n_miss++;
            $display("FAIL d_resp: got op=%0d sz=%0d src=%0d den=%0b cor=%0b data=%h param=%0d sink=%0b, expected op=%0d sz=%0d src=%0d den=%0b cor=%0b data=%h",
                     d_opcode, d_size, d_source, d_denied, d_corrupt, d_data, d_param, d_sink,
                     e.op, e.size, e.source, e.den, e.cor, e.data);
          end
        end
      end
      stalled = d_valid && !d_ready;
      snap = {3'b000, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
    end
  end

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      @(posedge clock);
      cyc++;
    end
    @(negedge clock);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s: %0d responses outstanding, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    vec_t vecs[21];
    int   waited;
    int   total_wait;

    //        op  sz  offset       mask  data          cor  e_op e_den e_cor e_data
    vecs[0]  = mk(3'd0, 2'd2, 32'h10,  4'hF, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vecs[1]  = mk(3'd4, 2'd2, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(3'd1, 2'd2, 32'h10,  4'h2, 32'h0000AB00, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vecs[3]  = mk(3'd4, 2'd2, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'hDEADABEF);
    vecs[4]  = mk(3'd4, 2'd2, 32'h1000,4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 1'b1, 32'h0);
    vecs[5]  = mk(3'd4, 2'd2, 32'h2,   4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 1'b1, 32'h0);
    vecs[6]  = mk(3'd3, 2'd2, 32'h10,  4'hF, 32'h12345678, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0);
    vecs[7]  = mk(3'd5, 2'd2, 32'h10,  4'hF, 32'h12345678, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0);
    vecs[8]  = mk(3'd2, 2'd2, 32'h10,  4'hF, 32'h12345678, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0);
    vecs[9]  = mk(3'd4, 2'd2, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'hDEADABEF);
    vecs[10] = mk(3'd0, 2'd2, 32'h20,  4'h3, 32'h55555555, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
    vecs[11] = mk(3'd0, 2'd0, 32'h13,  4'h8, 32'h11000000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vecs[12] = mk(3'd4, 2'd3, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 1'b1, 32'h0);
    vecs[13] = mk(3'd0, 2'd2, 32'h10,  4'hF, 32'h00000000, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0);
    vecs[14] = mk(3'd4, 2'd2, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'h11ADABEF);
    vecs[15] = mk(3'd4, 2'd2, 32'hFFFFFFFC, 4'hF, 32'h0,   1'b0, 3'd1, 1'b1, 1'b1, 32'h0);
    vecs[16] = mk(3'd4, 2'd1, 32'h12,  4'hC, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'h11ADABEF);
    vecs[17] = mk(3'd1, 2'd2, 32'h10,  4'h0, 32'hFFFFFFFF, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vecs[18] = mk(3'd4, 2'd2, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'h11ADABEF);
    vecs[19] = mk(3'd0, 2'd2, 32'hFFC, 4'hF, 32'h12345678, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vecs[20] = mk(3'd4, 2'd2, 32'hFFC, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'h12345678);

    // Reset behaviour
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_bit("reset_a_ready", a_ready, 1'b0);
    check_bit("reset_d_valid", d_valid, 1'b0);
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    check_bit("post_reset_a_ready", a_ready, 1'b1);
    check_bit("post_reset_d_valid", d_valid, 1'b0);
    @(posedge clock); #1;

    // Table vectors, back-to-back with d_ready held high
    total_wait = 0;
    for (int i = 0; i < 21; i++) begin
      send(vecs[i].op, vecs[i].size, SW'(i), vecs[i].addr, vecs[i].mask, vecs[i].data,
           vecs[i].corrupt,
           mk_exp(vecs[i].e_op, vecs[i].size, SW'(i), vecs[i].e_den, vecs[i].e_cor,
                  vecs[i].e_data),
           waited);
      total_wait += waited;
    end
    n_vec++;
    if (total_wait != 0) begin
      n_miss++;
      $display("FAIL throughput: got %0d stall cycles, expected 0", total_wait);
    end
    drain("table_drain");

    // Backpressure: queue fills after two Gets, third waits for a slot
    @(posedge clock); #1; d_ready = 1'b0;
    send(3'd4, 2'd2, 3'd5, BASE + 32'h10, 4'hF, 32'h0, 1'b0,
         mk_exp(3'd1, 2'd2, 3'd5, 1'b0, 1'b0, 32'h11ADABEF), waited);
    send(3'd4, 2'd2, 3'd6, BASE + 32'hFFC, 4'hF, 32'h0, 1'b0,
         mk_exp(3'd1, 2'd2, 3'd6, 1'b0, 1'b0, 32'h12345678), waited);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_bit("full_a_ready", a_ready, 1'b0);
      check_bit("full_d_valid", d_valid, 1'b1);
    end
    @(posedge clock); #1; d_ready = 1'b1;
    send(3'd4, 2'd2, 3'd7, BASE + 32'h10, 4'hF, 32'h0, 1'b0,
         mk_exp(3'd1, 2'd2, 3'd7, 1'b0, 1'b0, 32'h11ADABEF), waited);
    n_vec++;
    if (waited != 1) begin
      n_miss++;
      $display("FAIL no_bypass_wait: got %0d wait cycles, expected 1", waited);
    end
    drain("bp_drain");

    // Reset with two queued responses
    @(posedge clock); #1; d_ready = 1'b0;
    send(3'd0, 2'd2, 3'd1, BASE + 32'h40, 4'hF, 32'hCAFEF00D, 1'b0,
         mk_exp(3'd0, 2'd2, 3'd1, 1'b0, 1'b0, 32'h0), waited);
    send(3'd4, 2'd2, 3'd2, BASE + 32'h10, 4'hF, 32'h0, 1'b0,
         mk_exp(3'd1, 2'd2, 3'd2, 1'b0, 1'b0, 32'h11ADABEF), waited);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check_bit("mid_reset_a_ready", a_ready, 1'b0);
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    check_bit("after_reset_d_valid", d_valid, 1'b0);
    check_bit("after_reset_a_ready", a_ready, 1'b1);
    @(posedge clock); #1; d_ready = 1'b1;
    send(3'd4, 2'd2, 3'd3, BASE + 32'h40, 4'hF, 32'h0, 1'b0,
         mk_exp(3'd1, 2'd2, 3'd3, 1'b0, 1'b0, 32'hCAFEF00D), waited);
    send(3'd4, 2'd2, 3'd4, BASE + 32'h10, 4'hF, 32'h0, 1'b0,
         mk_exp(3'd1, 2'd2, 3'd4, 1'b0, 1'b0, 32'h11ADABEF), waited);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_tl_ul_ram_responder
`default_nettype wire
